// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared encodings for the data-memory arbiter
// Purpose: store-type and FSM state encodings used by the arbiter and its helpers.
// Ports: none (package).
package dm_arbiter_pkg;

  // Store-type encoding shared with the pipeline and DM.
  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } stype_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - requester and DM bus bundle for the arbiter
// Purpose: groups both requester ports and the DM port into one bundle.
// Ports (slave = arbiter view):
//   in : m_req, m_we, m_stype, m_addr, m_wdata, m_pc8 (per master), mem_rdata
//   out: m_gnt, m_ack, m_err, m_rdata, mem_write, mem_addr, mem_data,
//        mem_be, mem_stype, mem_pc8, mem_baddr
interface dm_arbiter_if #(
  parameter int MEM_AW = 12
) ();
  logic [1:0]        m_req;
  logic [1:0]        m_we;
  logic [1:0][1:0]   m_stype;
  logic [1:0][31:0]  m_addr;
  logic [1:0][31:0]  m_wdata;
  logic [1:0][31:0]  m_pc8;
  logic [1:0]        m_gnt;
  logic [1:0]        m_ack;
  logic [1:0]        m_err;
  logic [31:0]       m_rdata;
  logic              mem_write;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_be;
  logic [1:0]        mem_stype;
  logic [31:0]       mem_pc8;
  logic [31:0]       mem_baddr;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m_req, m_we, m_stype, m_addr, m_wdata, m_pc8, mem_rdata,
    output m_gnt, m_ack, m_err, m_rdata, mem_write, mem_addr, mem_data,
           mem_be, mem_stype, mem_pc8, mem_baddr
  );

  modport master (
    output m_req, m_we, m_stype, m_addr, m_wdata, m_pc8, mem_rdata,
    input  m_gnt, m_ack, m_err, m_rdata, mem_write, mem_addr, mem_data,
           mem_be, mem_stype, mem_pc8, mem_baddr
  );
endinterface

// File: rtl/dm_arbiter_be_gen.sv
// rtl/dm_arbiter_be_gen.sv - byte-enable and alignment decode
// Purpose: maps store type and low address bits to DM byte enables and flags
//          misaligned or reserved store types.
// Ports: stype_i (2), addr_lo_i (2) -> be_o (4), misalign_o (1).
module dm_arbiter_be_gen
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] stype_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] be_o,
  output logic       misalign_o
);

  always_comb begin
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    case (stype_i)
      ST_SW: begin
        be_o       = 4'b1111;
        misalign_o = |addr_lo_i;
      end
      ST_SH: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        misalign_o = addr_lo_i[0];
      end
      ST_SB: begin
        be_o = 4'b0001 << addr_lo_i;
      end
      default: begin
        // Reserved encoding is always rejected.
        misalign_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-master round-robin arbiter and DM access sequencer
// Purpose: shares one DM port between the memory stage (master 0) and the
//          debug/DMA bridge (master 1); grants, captures, drives DM for one
//          cycle, then acknowledges with the read word or an error.
// Ports: clk, reset (sync, active-low), bus (dm_arbiter_if.slave).
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  logic        we_q, id_q, err_q;
  logic [1:0]  stype_q;
  logic [31:0] addr_q, wdata_q, pc8_q;
  logic [3:0]  be_q;
  logic [1:0]  ack_q, err_o_q;
  logic [31:0] rdata_q;

  logic        winner;
  logic        grant;
  logic        in_access;
  logic [3:0]  be_w;
  logic        misalign_w;
  logic        range_err_w;

  // Under contention the pointer decides; otherwise the lone requester wins.
  always_comb begin
    winner = bus.m_req[1];
    if (bus.m_req == 2'b11) begin
      winner = rr_q;
    end
  end

  assign grant     = (state_q == S_IDLE) & reset & (|bus.m_req);
  assign in_access = (state_q == S_ACCESS);

  dm_arbiter_be_gen u_be_gen (
    .stype_i    (bus.m_stype[winner]),
    .addr_lo_i  (bus.m_addr[winner][1:0]),
    .be_o       (be_w),
    .misalign_o (misalign_w)
  );

  // Any address bit above the DM word range makes the access out of range.
  assign range_err_w = |bus.m_addr[winner][31:MEM_AW+2];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ACCESS;
          rr_d    = ~winner;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      stype_q <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      pc8_q   <= '0;
      be_q    <= 4'b0000;
      ack_q   <= 2'b00;
      err_o_q <= 2'b00;
      rdata_q <= '0;
    end else begin
      ack_q   <= 2'b00;
      err_o_q <= 2'b00;
      if (grant) begin
        we_q    <= bus.m_we[winner];
        id_q    <= winner;
        err_q   <= misalign_w | range_err_w;
        stype_q <= bus.m_stype[winner];
        addr_q  <= bus.m_addr[winner];
        wdata_q <= bus.m_wdata[winner];
        pc8_q   <= bus.m_pc8[winner];
        be_q    <= be_w;
      end
      if (in_access) begin
        // Rejected accesses return zero rather than whatever DM presents.
        rdata_q        <= err_q ? 32'h0 : bus.mem_rdata;
        ack_q[id_q]    <= 1'b1;
        err_o_q[id_q]  <= err_q;
      end
    end
  end

  assign bus.m_gnt     = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.m_ack     = ack_q;
  assign bus.m_err     = err_o_q;
  assign bus.m_rdata   = rdata_q;
  // Gating with reset kills the write in the same cycle reset is asserted.
  assign bus.mem_write = in_access & we_q & ~err_q & reset;
  assign bus.mem_addr  = addr_q[MEM_AW+1:2];
  assign bus.mem_data  = wdata_q;
  assign bus.mem_be    = in_access ? be_q : 4'b0000;
  assign bus.mem_stype = stype_q;
  assign bus.mem_pc8   = pc8_q;
  assign bus.mem_baddr = addr_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - randomized scoreboard bench for dm_arbiter
module tb_dm_arbiter;
  localparam int MEM_AW = 12;
  localparam int DEPTH  = 1 << MEM_AW;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic clear_dm = 1'b1;
  always #5 clk = ~clk;

  dm_arbiter_if #(.MEM_AW(MEM_AW)) bus ();
  dm_arbiter #(.MEM_AW(MEM_AW)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  // DM model: combinational read, byte-lane write with low-byte replication.
  logic [31:0] dm [DEPTH];
  logic [31:0] dm_wr;
  always_comb begin
    case (bus.mem_stype)
      2'b00:   dm_wr = bus.mem_data;
      2'b01:   dm_wr = {2{bus.mem_data[15:0]}};
      default: dm_wr = {4{bus.mem_data[7:0]}};
    endcase
  end
  always @(posedge clk) begin
    if (clear_dm) begin
      for (int k = 0; k < DEPTH; k++) dm[k] <= 32'h0;
    end else if (bus.mem_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) dm[bus.mem_addr][8*b +: 8] <= dm_wr[8*b +: 8];
    end
  end
  assign bus.mem_rdata = dm[bus.mem_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } resp_t;
  resp_t sb_q[$];

  // Reference model state: a word-addressed memory and the requester view.
  logic [31:0] ref_mem [DEPTH];
  logic [1:0]  req_m = 2'b00;
  logic        we_m [2];
  logic [1:0]  st_m [2];
  logic [31:0] addr_m [2], wd_m [2], pc_m [2];
  int          free_at [2];
  logic        rr_m = 1'b0;
  logic        acc_on = 1'b0;
  logic        acc_id, acc_we, acc_err;
  logic [3:0]  acc_be;
  int          acc_word;
  logic [31:0] acc_rdata, acc_new, acc_wd, acc_pc, acc_addr;
  logic [1:0]  acc_st;

  function automatic logic model_err(input logic [1:0] st, input logic [31:0] a);
    if (a >= 32'(DEPTH * 4)) return 1'b1;
    case (st)
      2'd0:    return (a % 4) != 0;
      2'd1:    return (a % 2) != 0;
      2'd2:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] st, input logic [31:0] a);
    case (st)
      2'd0:    return 4'hF;
      2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
      2'd2:    return 4'(1 << (a % 4));
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [1:0] st,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (st == 2'd0) r = wd;
    else if (st == 2'd1) r[16*((a/2)%2) +: 16] = wd[15:0];
    else r[8*(a%4) +: 8] = wd[7:0];
    return r;
  endfunction

  task automatic setreq(input int i, input logic we, input logic [1:0] st,
                        input logic [31:0] a, input logic [31:0] wd);
    we_m[i]   = we;
    st_m[i]   = st;
    addr_m[i] = a;
    wd_m[i]   = wd;
    pc_m[i]   = $urandom;
    req_m[i]  = 1'b1;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the model.
  task automatic step();
    logic [1:0] eg;
    logic       w;
    for (int i = 0; i < 2; i++) begin
      bus.m_req[i]   = req_m[i];
      bus.m_we[i]    = we_m[i];
      bus.m_stype[i] = st_m[i];
      bus.m_addr[i]  = addr_m[i];
      bus.m_wdata[i] = wd_m[i];
      bus.m_pc8[i]   = pc_m[i];
    end
    @(negedge clk);
    if (acc_on) begin
      check("mem_write", 32'(bus.mem_write), 32'(acc_we && !acc_err && rst_n));
      check("mem_be", 32'(bus.mem_be), 32'(acc_be));
      check("mem_addr", 32'(bus.mem_addr), 32'(acc_word));
      check("mem_data", bus.mem_data, acc_wd);
      check("mem_pc8", bus.mem_pc8, acc_pc);
      check("mem_baddr", bus.mem_baddr, acc_addr);
      check("mem_stype", 32'(bus.mem_stype), 32'(acc_st));
    end else begin
      check("idle_write", 32'(bus.mem_write), 32'h0);
      check("idle_be", 32'(bus.mem_be), 32'h0);
    end
    eg = 2'b00;
    w  = 1'b0;
    if (!acc_on && rst_n && req_m != 2'b00) begin
      w = (req_m == 2'b11) ? rr_m : req_m[1];
      eg[w] = 1'b1;
    end
    check("gnt", 32'(bus.m_gnt), 32'(eg));
    if (!rst_n) begin
      if (acc_on) free_at[acc_id] = cyc;
      rr_m   = 1'b0;
      acc_on = 1'b0;
    end else if (acc_on) begin
      if (acc_we && !acc_err) ref_mem[acc_word] = acc_new;
      sb_q.push_back('{id: acc_id, err: acc_err, rdata: acc_rdata, due: cyc + 1});
      free_at[acc_id] = cyc + 2;
      acc_on = 1'b0;
    end else if (eg != 2'b00) begin
      acc_id    = w;
      acc_we    = we_m[w];
      acc_st    = st_m[w];
      acc_addr  = addr_m[w];
      acc_wd    = wd_m[w];
      acc_pc    = pc_m[w];
      acc_err   = model_err(acc_st, acc_addr);
      acc_be    = model_be(acc_st, acc_addr);
      acc_word  = int'((acc_addr / 4) % DEPTH);
      acc_rdata = acc_err ? 32'h0 : ref_mem[acc_word];
      acc_new   = model_merge(ref_mem[acc_word], acc_st, acc_addr, acc_wd);
      acc_on    = 1'b1;
      rr_m      = ~w;
      req_m[w]  = 1'b0;
      free_at[w] = 32'h3fff_ffff;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic can_req(input int i);
    return !req_m[i] && (cyc >= free_at[i]);
  endfunction

  task automatic wait_free(input int i);
    int n = 0;
    while (!can_req(i) && n < 20) begin step(); n++; end
    total++;
    if (n >= 20) begin bad++; $display("FAIL wait_free m%0d: timed out after %0d cycles", i, n); end
  endtask

  task automatic drain();
    int n = 0;
    while ((req_m != 2'b00 || acc_on || sb_q.size() != 0) && n < 50) begin step(); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL drain: timed out, %0d responses pending", sb_q.size()); end
  endtask

  // Monitor: pops the scoreboard on every acknowledge.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bus.m_ack[i] === 1'b1) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ack: got ack on m%0d expected none (cycle %0d)", i, cyc);
          end else begin
            r = sb_q.pop_front();
            check("ack_id", 32'(i), 32'(r.id));
            check("ack_cycle", 32'(cyc), 32'(r.due));
            check("ack_err", 32'(bus.m_err[i]), 32'(r.err));
            check("ack_rdata", bus.m_rdata, r.rdata);
          end
        end else if (rst_n) begin
          check("err_no_ack", 32'(bus.m_err[i]), 32'h0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      we_m[i] = 1'b0; st_m[i] = 2'b00; addr_m[i] = 32'h0;
      wd_m[i] = 32'h0; pc_m[i] = 32'h0; free_at[i] = 0;
    end
    bus.m_req = 2'b00; bus.m_we = 2'b00; bus.m_stype = '0;
    bus.m_addr = '0; bus.m_wdata = '0; bus.m_pc8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.m_gnt), 32'h0);
    check("rst_ack", 32'(bus.m_ack), 32'h0);
    check("rst_err", 32'(bus.m_err), 32'h0);
    check("rst_rdata", bus.m_rdata, 32'h0);
    check("rst_write", 32'(bus.mem_write), 32'h0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_data", bus.mem_data, 32'h0);
    check("rst_be", 32'(bus.mem_be), 32'h0);
    check("rst_stype", 32'(bus.mem_stype), 32'h0);
    check("rst_pc8", bus.mem_pc8, 32'h0);
    check("rst_baddr", bus.mem_baddr, 32'h0);
    clear_dm = 1'b0;

    // Requests pending while in reset must not be granted.
    setreq(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    setreq(1, 1'b1, 2'b10, 32'h13, 32'h000000AB);
    step();
    step();
    rst_n = 1'b1;

    // Contention from reset: m0, m1, m0, m1.
    step(); step(); step();
    wait_free(1);
    setreq(1, 1'b0, 2'b00, 32'h10, 32'h0);
    wait_free(0);
    setreq(0, 1'b0, 2'b00, 32'h10, 32'h0);
    drain();

    // Rejected accesses, then a load of word 0 that must be untouched.
    setreq(0, 1'b1, 2'b00, 32'h0, 32'h11223344);
    drain();
    setreq(0, 1'b1, 2'b01, 32'h21, 32'h5555AAAA);
    drain();
    setreq(1, 1'b1, 2'b00, 32'h22, 32'h66667777);
    drain();
    setreq(0, 1'b1, 2'b11, 32'h30, 32'h88889999);
    drain();
    setreq(1, 1'b1, 2'b00, 32'h0000_4000, 32'hCAFEF00D);
    drain();
    setreq(0, 1'b0, 2'b00, 32'h0, 32'h0);
    drain();

    // Randomized traffic on a small window so accesses overlap.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (can_req(i) && ($urandom_range(0, 3) != 0)) begin
          logic [31:0] a;
          a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
          if ($urandom_range(0, 15) == 0) a = a | 32'h0000_4000;
          setreq(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end
      end
      step();
    end
    drain();

    // Reset during the access cycle drops the store.
    setreq(0, 1'b1, 2'b00, 32'h14, 32'h12345678);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    setreq(0, 1'b0, 2'b00, 32'h14, 32'h0);
    setreq(1, 1'b0, 2'b00, 32'h14, 32'h0);
    drain();

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL final_queue: got %0d pending expected 0", sb_q.size());
    end
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer in front of the data memory (DM). It shares the single DM port between the pipeline's memory stage (master 0) and a debug/DMA bridge (master 1). It also derives byte enables from address and store type, rejects misaligned or out-of-range accesses, and returns the read word with an acknowledge. It sits between the requesters and DM; DM itself is unchanged.

## Interface
- `MEM_AW`, default 12: DM word-address width, so `mem_addr` is `[MEM_AW+1:2]`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low.
- `m_req[i]` in 1 (i=0,1): access request, level.
- `m_we[i]` in 1: 1 = store, 0 = load.
- `m_stype[i]` in 2: `sw`/`sh`/`sb` encoding from the shared header.
- `m_addr[i]` in 32: byte address.
- `m_wdata[i]` in 32: store data, unshifted; DM replicates low bytes itself.
- `m_pc8[i]` in 32: PC+8 tag, forwarded to DM for the store trace.
- `m_gnt[i]` out 1: one-cycle pulse; request fields captured.
- `m_ack[i]` out 1: one-cycle pulse; access complete.
- `m_err[i]` out 1: valid with `m_ack[i]`; access was rejected.
- `m_rdata` out 32: read word, valid with any `m_ack`; shared by both masters.
- `mem_write` out 1: DM write strobe.
- `mem_addr` out `MEM_AW`: DM word address.
- `mem_data` out 32: DM write data.
- `mem_be` out 4: byte enables.
- `mem_stype` out 2: store type to DM.
- `mem_pc8` out 32: PC+8 tag to DM.
- `mem_baddr` out 32: full byte address to DM.
- `mem_rdata` in 32: DM combinational read data.

## Operation
- FSM has two states, IDLE and ACCESS. Reset state is IDLE.
- IDLE:
  - If any `m_req` is high, select a master, pulse its `m_gnt`, and register `we`, `stype`, `addr`, `wdata`, `pc8`, the master id and the error flag. Go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - DM outputs are driven from the captured fields.
  - `mem_write` = captured `we` & ~error & `reset`.
  - At the end of the cycle, register `m_rdata` <= `mem_rdata` and pulse `m_ack`/`m_err` for the captured id in the next cycle. Return to IDLE.
- Arbitration is round-robin with pointer `rr`, reset value 0.
  - If only one master requests, it wins.
  - If both request, master `rr` wins.
  - After every grant, `rr` <= ~winner.
- Byte enables:
  - `sw` -> 1111.
  - `sh` -> 0011 if `addr[1]`=0, otherwise 1100.
  - `sb` -> 0001 shifted left by `addr[1:0]`.
- Error conditions:
  - `sw` with `addr[1:0]` != 0.
  - `sh` with `addr[0]` = 1.
  - `stype` = 2'b11.
  - `addr[31:MEM_AW+2]` != 0.
- On error: `mem_write` stays 0, `m_err`=1 with the ack, and `m_rdata` = 0.
- For loads, `m_rdata` is the raw word. Byte/half extraction and sign extension belong to the requester.
- A master must not raise a new request before receiving its ack. Fields need only be valid in the cycle `m_gnt` pulses.

## Timing
- Cycle N, state IDLE, request seen: `m_gnt` is high in cycle N (combinational from IDLE & req & winner), and fields are captured at the end of N.
- Cycle N+1, ACCESS: DM outputs are valid and the DM write happens at the end of N+1.
- Cycle N+2: `m_ack` and `m_rdata` are valid. The FSM is back in IDLE and may grant again in the same cycle.
- Throughput is one access per 2 cycles. A store is visible to a subsequent load by the other master.
- Reset values:
  - Outputs: `m_gnt`=0, `m_ack`=0, `m_err`=0, `m_rdata`=0, `mem_write`=0.
  - `mem_addr`, `mem_data`, `mem_baddr`, `mem_pc8`, `mem_be`, `mem_stype` = 0.
- `reset` low in ACCESS: `mem_write` is forced 0 in that cycle, no ack is issued, and the transaction is dropped.
- `reset` low in IDLE with a request pending: no `m_gnt`.
- Outside ACCESS, `mem_write` is 0 and `mem_be` is 0000.

## Structure
- The `sw`/`sh`/`sb` encodings (00/01/10) and the state encoding live in the shared header `head.v`.
- One combinational sub-module, `be_gen`, takes (`stype`, `addr[1:0]`) and produces (`be`, `misalign`). The error flag combines `misalign` with the range check in `dm_arbiter`.

## Test plan
- **Single store:** m0 `sw`, addr 0x0000_0010, wdata 0xDEADBEEF -> `m_gnt[0]` in cycle N, `mem_write`=1, `mem_addr`=4, `mem_be`=1111 in N+1, `m_ack[0]`=1 and `m_err`=0 in N+2.
- **Byte store then load:** m1 `sb` to addr 0x13 with wdata 0x000000AB -> `mem_be`=1000. A following m1 load of 0x10 returns 0xAB in `m_rdata[31:24]`.
- **Contention:** both masters request continuously from reset -> grant order m0, m1, m0, m1, with a grant every 2 cycles.
- **Misalignment:** `sh` at 0x21, `sw` at 0x22, and `stype`=11 -> each gives `mem_write`=0, `m_err`=1 and `m_rdata`=0.
- **Out of range:** `sw` at 0x0000_4000 with `MEM_AW`=12 -> `m_err`=1 and no write. A later load of word 0 is unchanged.
- **Reset in ACCESS:** assert `reset` low during the N+1 cycle of a store -> `mem_write`=0, no `m_ack`, memory word unchanged. After reset is released, a fresh request is granted with `rr`=0.
